// File: rtl/uart_rx_ctrl_pkg.sv
// uart_rx_ctrl_pkg: register map, STATUS/CTRL bit positions and timeout state encodings
package uart_rx_ctrl_pkg;
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam int ST_RXNE  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVR   = 2;
  localparam int ST_TMO   = 3;
  localparam int CT_EN    = 0;
  localparam int CT_IE    = 1;
  localparam int CT_FLUSH = 2;
  typedef enum logic [1:0] {TO_IDLE = 2'd0, TO_RUN = 2'd1, TO_FIRED = 2'd2} to_state_e;
endpackage

// File: rtl/uart_rx_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO with flush, occupancy count and a read register loaded on pop
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wptr, rptr;
  assign full  = count[AW];
  assign empty = count == '0;
  always_ff @(posedge i_Clock)
    if (push) mem[wptr] <= wr_data;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr    <= rptr + AW'(1);
        rd_data <= mem[rptr];
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART RX byte FIFO with DATA/STATUS/CTRL bus registers and level IRQ
// Define UART_RX_TIMEOUT_EN to compile in the idle-timeout FSM (STATUS.TMO).
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int FIFO_AW      = 4,
  parameter int TIMEOUT_CLKS = 3480
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  input  logic       i_Sel,
  input  logic       i_We,
  input  logic       i_Re,
  input  logic [1:0] i_Addr,
  input  logic [7:0] i_Wdata,
  output logic [7:0] o_Rdata,
  output logic       o_Irq
);
  logic wr, rd, pop, push, flush, ovr_set, w1c_ovr;
  logic en, ie, ovr, tmo, full, empty, data_sel;
  logic [FIFO_AW:0] count;
  logic [7:0] fifo_rd, rdata_q, status;
  assign wr      = i_Sel & i_We;
  assign rd      = i_Sel & i_Re;
  assign flush   = wr && i_Addr == ADDR_CTRL && i_Wdata[CT_FLUSH];
  assign pop     = rd && i_Addr == ADDR_DATA && !empty;
  assign push    = i_Rx_DV & en & !flush & (!full | pop);
  assign ovr_set = i_Rx_DV & en & !flush & full & !pop;
  assign w1c_ovr = wr && i_Addr == ADDR_STATUS && i_Wdata[ST_OVR];
  assign status  = {4'b0, tmo, ovr, full, !empty};
  sync_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (i_Rx_Byte),
    .rd_data (fifo_rd),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      en       <= 1'b1;
      ie       <= 1'b0;
      ovr      <= 1'b0;
      o_Irq    <= 1'b0;
      rdata_q  <= 8'h00;
      data_sel <= 1'b0;
    end else begin
      ovr   <= (ovr & !w1c_ovr) | ovr_set;
      o_Irq <= ie & (!empty | ovr | tmo);
      if (wr && i_Addr == ADDR_CTRL) begin
        en <= i_Wdata[CT_EN];
        ie <= i_Wdata[CT_IE];
      end
      if (rd) begin
        data_sel <= pop;
        rdata_q  <= i_Addr == ADDR_STATUS ? status :
                    i_Addr == ADDR_CTRL   ? {6'b0, ie, en} : 8'h00;
      end
    end
  end
  // the FIFO read register only moves on a pop, so it can serve DATA reads directly
  assign o_Rdata = data_sel ? fifo_rd : rdata_q;
`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);
  to_state_e st, st_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [FIFO_AW:0] count_nx;
  logic w1c_tmo, act, active;
  assign w1c_tmo  = wr && i_Addr == ADDR_STATUS && i_Wdata[ST_TMO];
  assign act      = push | pop;
  assign count_nx = flush ? '0 : count + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
  assign active   = !flush & en & (count_nx != '0);
  assign tmo      = st == TO_FIRED;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      st   <= TO_IDLE;
      tcnt <= '0;
    end else begin
      st   <= st_nx;
      tcnt <= tcnt_nx;
    end
  end
  always_comb begin
    st_nx   = TO_RUN;
    tcnt_nx = '0;
    if (!active) st_nx = TO_IDLE;
    else if (st == TO_RUN && !act) begin
      st_nx   = tcnt == TW'(TIMEOUT_CLKS-1) ? TO_FIRED : TO_RUN;
      tcnt_nx = tcnt + TW'(1);
    end else if (st == TO_FIRED && !act && !w1c_tmo) st_nx = TO_FIRED;
  end
`else
  assign tmo = 1'b0;
`endif
endmodule
